unidade_busca: RTL and testbench
================================

Name: unidade_busca

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Holds the program counter and drives the word-aligned fetch address into the memory's address input.
- Captures the memory's combinational instruction output into the IF/ID pipeline register.
- Handles sequential increment, stall, flush, and branch/jump redirect from later stages.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- IMEM_WORDS, 64: instruction memory depth in 32-bit words; used only for the out-of-range flag.
- NOP_WORD, 32'h0000_0000: instruction word placed in IF/ID on reset or flush (sll $0,$0,0).

Ports:
- clock  in  1  rising-edge clock, single domain.
- reset_n  in  1  synchronous, active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  squash IF/ID contents (PC still advances).
- branch_taken  in  1  branch resolved taken this cycle.
- branch_target  in  32  branch destination address.
- jump  in  1  jump decoded this cycle.
- jump_target  in  32  jump destination address.
- instrucao  in  32  instruction word from instruction memory (combinational on endereco).
- endereco  out  32  current PC, to instruction memory address input.
- if_id_instrucao  out  32  registered instruction for decode.
- if_id_pc_mais4  out  32  registered PC+4 of that instruction.
- if_id_valido  out  1  IF/ID holds a real instruction.
- pc_fora_limite  out  1  current PC is at or beyond IMEM_WORDS*4.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - PC <= RESET_PC.
  - if_id_instrucao <= NOP_WORD, if_id_pc_mais4 <= 0, if_id_valido <= 0.
  - Reset overrides every other input.
  - Asserting reset mid-stall or mid-redirect discards that operation completely.
- endereco = PC continuously (combinational).
  - PC[1:0] is always 00; target bits [1:0] are forced to 0 when loaded.
- pc_fora_limite = (PC >= IMEM_WORDS*4), combinational, with no effect on fetch.
- Next-PC priority per rising edge, highest first:
  1. reset
  2. jump: PC <= jump_target
  3. branch_taken: PC <= branch_target
  4. stall: PC holds
  5. otherwise PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0)
- IF/ID update per edge, highest first:
  1. reset
  2. jump, branch_taken or flush: load NOP_WORD, pc_mais4 <= 0, valido <= 0
  3. stall: all IF/ID registers hold
  4. otherwise: instrucao <= instrucao input, pc_mais4 <= PC+4, valido <= 1
- Redirect wins over stall: a taken branch/jump during a stall still updates PC and squashes IF/ID.
- flush with stall: IF/ID is squashed, PC holds.
- Latency:
  - The instruction addressed at cycle N appears on if_id_* after edge N+1.
  - Redirect penalty is one bubble: the target instruction reaches IF/ID one edge after the redirect edge.
- No internal state machine beyond PC and IF/ID registers.
- All registers update only on the rising edge of clock.

Optional Feature:
- Macro BUSCA_CONTADORES_EN.
- When defined, adds three outputs: cont_ciclos[31:0], cont_stall[31:0], cont_redirect[31:0].
  - cont_ciclos increments on every non-reset edge.
  - cont_stall increments on edges where stall=1 and no redirect occurs.
  - cont_redirect increments on edges where jump or branch_taken is 1.
  - All three clear to 0 on reset and wrap modulo 2^32.
- When undefined, these ports and registers do not exist and fetch behaviour is identical.

Test Plan:
- Reset then 4 free-running cycles, memory returning word = address:
  - endereco sequence 0,4,8,12.
  - if_id_instrucao 0,4,8 with pc_mais4 4,8,12.
  - valido rises on the first post-reset edge.
- PC=8, stall=1 for 2 cycles:
  - endereco stays 8 and IF/ID holds the word from address 4 for both cycles.
  - After release, endereco becomes 12.
- PC=16, branch_taken=1, branch_target=32'h0000_0042:
  - Next endereco = 32'h40; IF/ID = NOP_WORD with valido=0.
  - The following edge loads the word at 0x40 with pc_mais4 = 0x44.
- Same edge: jump=1 to 0x80, branch_taken=1 to 0x20, stall=1:
  - endereco becomes 0x80 (jump wins, stall ignored); IF/ID squashed.
- PC=0xFC with IMEM_WORDS=64:
  - pc_fora_limite = 0.
  - Next edge: PC=0x100 and pc_fora_limite = 1.
  - A separate run with PC forced to 0xFFFF_FFFC wraps to 0.
- reset_n=0 asserted during stall and flush with PC=0x24:
  - Next edge: PC=RESET_PC, valido=0.
  - With BUSCA_CONTADORES_EN defined, all counters read 0.

Source files
------------

// File: rtl/unidade_busca_if.sv
// Fetch-stage bundle: redirect/hazard controls, instruction-memory port and IF/ID outputs.
// master = fetch unit, slave = surrounding pipeline / memory.
interface unidade_busca_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instrucao;
    logic [31:0] endereco;
    logic [31:0] if_id_instrucao;
    logic [31:0] if_id_pc_mais4;
    logic        if_id_valido;
    logic        pc_fora_limite;

    modport master (
        input  stall, flush, branch_taken, branch_target, jump, jump_target, instrucao,
        output endereco, if_id_instrucao, if_id_pc_mais4, if_id_valido, pc_fora_limite
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, jump, jump_target, instrucao,
        input  endereco, if_id_instrucao, if_id_pc_mais4, if_id_valido, pc_fora_limite
    );
endinterface

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional cycle/stall/redirect counters when BUSCA_CONTADORES_EN is defined.
module unidade_busca #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    unidade_busca_if.master   bus
`ifdef BUSCA_CONTADORES_EN
    ,
    output logic [31:0]       cont_ciclos,
    output logic [31:0]       cont_stall,
    output logic [31:0]       cont_redirect
`endif
);
    localparam logic [32:0] LIMITE = 33'(IMEM_WORDS) * 33'd4;

    logic [31:0] pc;
    logic [31:0] pc_mais4;
    logic        redirect;

    assign pc_mais4 = pc + 32'd4;
    assign redirect = bus.jump | bus.branch_taken;

    assign bus.endereco       = pc;
    assign bus.pc_fora_limite = ({1'b0, pc} >= LIMITE);

    // Jump beats branch; any redirect beats stall. Targets are word-aligned on load.
    always_ff @(posedge clock) begin
        if (!reset_n)
            pc <= RESET_PC;
        else if (bus.jump)
            pc <= bus.jump_target & ~32'h3;
        else if (bus.branch_taken)
            pc <= bus.branch_target & ~32'h3;
        else if (!bus.stall)
            pc <= pc_mais4;
    end

    // A squash (redirect or flush) wins over stall so the bubble always enters IF/ID.
    always_ff @(posedge clock) begin
        if (!reset_n || redirect || bus.flush) begin
            bus.if_id_instrucao <= NOP_WORD;
            bus.if_id_pc_mais4  <= 32'd0;
            bus.if_id_valido    <= 1'b0;
        end else if (!bus.stall) begin
            bus.if_id_instrucao <= bus.instrucao;
            bus.if_id_pc_mais4  <= pc_mais4;
            bus.if_id_valido    <= 1'b1;
        end
    end

`ifdef BUSCA_CONTADORES_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cont_ciclos   <= 32'd0;
            cont_stall    <= 32'd0;
            cont_redirect <= 32'd0;
        end else begin
            cont_ciclos <= cont_ciclos + 32'd1;
            if (redirect)
                cont_redirect <= cont_redirect + 32'd1;
            else if (bus.stall)
                cont_stall <= cont_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca; memory model returns word = address.
module tb_unidade_busca;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;
    int   exp_cic;
    int   exp_stl;
    int   exp_red;

    unidade_busca_if bus ();

`ifdef BUSCA_CONTADORES_EN
    logic [31:0] cont_ciclos, cont_stall, cont_redirect;
    unidade_busca dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .cont_ciclos(cont_ciclos), .cont_stall(cont_stall), .cont_redirect(cont_redirect)
    );
`else
    unidade_busca dut (.clock(clock), .reset_n(reset_n), .bus(bus));
`endif

    assign bus.instrucao = bus.endereco;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advances one edge, keeping an independent count of what the counters should read.
    task automatic step();
        if (!reset_n) begin
            exp_cic = 0; exp_stl = 0; exp_red = 0;
        end else begin
            exp_cic++;
            if (bus.jump || bus.branch_taken) exp_red++;
            else if (bus.stall) exp_stl++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                            input logic v);
        chk({tag, ".ins"}, bus.if_id_instrucao, ins);
        chk({tag, ".pc4"}, bus.if_id_pc_mais4, p4);
        chk({tag, ".val"}, {31'd0, bus.if_id_valido}, {31'd0, v});
    endtask

    task automatic chk_cont(input string tag);
`ifdef BUSCA_CONTADORES_EN
        chk({tag, ".cic"}, cont_ciclos, 32'(exp_cic));
        chk({tag, ".stl"}, cont_stall, 32'(exp_stl));
        chk({tag, ".red"}, cont_redirect, 32'(exp_red));
`else
        if (tag.len() == 0) $display("unused");
`endif
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_cic = 0; exp_stl = 0; exp_red = 0;
        reset_n = 1'b0;
        bus.stall = 0; bus.flush = 0; bus.jump = 0; bus.branch_taken = 0;
        bus.jump_target = 32'h0; bus.branch_target = 32'h0;

        // Reset overrides a pending redirect.
        bus.branch_taken = 1; bus.branch_target = 32'h50;
        step(); step();
        bus.branch_taken = 0;
        chk("rst.pc", bus.endereco, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk("rst.lim", {31'd0, bus.pc_fora_limite}, 32'd0);
        chk_cont("rst");

        // Free-running fetch.
        reset_n = 1'b1;
        step(); chk("seq1.pc", bus.endereco, 32'h4); chk_ifid("seq1", 32'h0, 32'h4, 1'b1);
        step(); chk("seq2.pc", bus.endereco, 32'h8); chk_ifid("seq2", 32'h4, 32'h8, 1'b1);

        // Stall two cycles at PC=8.
        bus.stall = 1;
        step(); chk("stl1.pc", bus.endereco, 32'h8); chk_ifid("stl1", 32'h4, 32'h8, 1'b1);
        step(); chk("stl2.pc", bus.endereco, 32'h8); chk_ifid("stl2", 32'h4, 32'h8, 1'b1);
        bus.stall = 0;
        step(); chk("rel.pc", bus.endereco, 32'hC); chk_ifid("rel", 32'h8, 32'hC, 1'b1);
        step(); chk("seq4.pc", bus.endereco, 32'h10);

        // Taken branch at PC=16, misaligned target.
        bus.branch_taken = 1; bus.branch_target = 32'h42;
        step(); chk("br.pc", bus.endereco, 32'h40); chk_ifid("br", 32'h0, 32'h0, 1'b0);
        bus.branch_taken = 0;
        step(); chk("brt.pc", bus.endereco, 32'h44); chk_ifid("brt", 32'h40, 32'h44, 1'b1);

        // Jump + branch + stall together: jump wins.
        bus.jump = 1; bus.jump_target = 32'h80;
        bus.branch_taken = 1; bus.branch_target = 32'h20; bus.stall = 1;
        step(); chk("jbs.pc", bus.endereco, 32'h80); chk_ifid("jbs", 32'h0, 32'h0, 1'b0);
        bus.jump = 0; bus.branch_taken = 0; bus.stall = 0;

        // Flush alone advances PC; flush with stall holds PC.
        bus.flush = 1;
        step(); chk("fl.pc", bus.endereco, 32'h84); chk_ifid("fl", 32'h0, 32'h0, 1'b0);
        bus.stall = 1;
        step(); chk("fls.pc", bus.endereco, 32'h84); chk_ifid("fls", 32'h0, 32'h0, 1'b0);
        bus.flush = 0; bus.stall = 0;
        step(); chk("fla.pc", bus.endereco, 32'h88); chk_ifid("fla", 32'h84, 32'h88, 1'b1);

        // Memory-range boundary.
        bus.jump = 1; bus.jump_target = 32'hFE;
        step(); chk("lim0.pc", bus.endereco, 32'hFC);
        chk("lim0.f", {31'd0, bus.pc_fora_limite}, 32'd0);
        bus.jump = 0;
        step(); chk("lim1.pc", bus.endereco, 32'h100);
        chk("lim1.f", {31'd0, bus.pc_fora_limite}, 32'd1);
        chk_ifid("lim1", 32'hFC, 32'h100, 1'b1);

        // 32-bit wrap.
        bus.jump = 1; bus.jump_target = 32'hFFFF_FFFC;
        step(); chk("wr0.pc", bus.endereco, 32'hFFFF_FFFC);
        chk("wr0.f", {31'd0, bus.pc_fora_limite}, 32'd1);
        bus.jump = 0;
        step(); chk("wr1.pc", bus.endereco, 32'h0);
        chk("wr1.f", {31'd0, bus.pc_fora_limite}, 32'd0);
        chk_ifid("wr1", 32'hFFFF_FFFC, 32'h0, 1'b1);
        chk_cont("pre");

        // Reset during stall + flush + branch at PC=0x24.
        bus.jump = 1; bus.jump_target = 32'h24;
        step(); chk("r24.pc", bus.endereco, 32'h24);
        bus.jump = 0;
        bus.stall = 1; bus.flush = 1; bus.branch_taken = 1; bus.branch_target = 32'h60;
        reset_n = 1'b0;
        step();
        chk("mrst.pc", bus.endereco, 32'h0);
        chk_ifid("mrst", 32'h0, 32'h0, 1'b0);
        chk_cont("mrst");
        bus.stall = 0; bus.flush = 0; bus.branch_taken = 0;
        reset_n = 1'b1;
        step(); chk("post.pc", bus.endereco, 32'h4); chk_ifid("post", 32'h0, 32'h4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
